// File: rtl/fifo_mmio_reader.sv
// fifo_mmio_reader: prefetches words from the FT receive FIFO into a 2-entry buffer and
// presents them as DATA/STAT/CTRL/COUNT MMIO registers. Define FIFO_RD_IRQ_EN for the irq output.
module fifo_mmio_reader #(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  read,
    input  logic                  write,
    input  logic [4:0]            addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_data_valid,
    input  logic                  fifo_rd_rst_busy,
    output logic                  fifo_rd_en
`ifdef FIFO_RD_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_STAT  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    logic                  wr_en;
    logic                  wr_data_sel;
    logic                  wr_stat;
    logic                  wr_ctrl;
    logic                  wr_count;
    logic                  flush;
    logic                  pop_req;
    logic                  pop_ok;
    logic                  push_req;
    logic                  push_ok;
    logic                  ovf_set;
    logic                  udf_set;
    logic                  buf_valid;
    logic                  buf_full;
    logic                  ctrl_irq_en;
    logic [2:0]            occ_sum;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic                  inflight_reg;
    logic                  drop_reg;
    logic                  ovf_reg;
    logic                  udf_reg;
    logic                  enable_reg;
    logic [31:0]           count_reg;
    logic [DATA_WIDTH-1:0] head;
    logic [29:0]           head_ext;
    logic                  unused_bits;

    assign unused_bits = ^{read, addr[4:2], wr_data};

    // Bus decode
    assign wr_en       = cs & write;
    assign wr_data_sel = wr_en & (addr[1:0] == REG_DATA);
    assign wr_stat     = wr_en & (addr[1:0] == REG_STAT);
    assign wr_ctrl     = wr_en & (addr[1:0] == REG_CTRL);
    assign wr_count    = wr_en & (addr[1:0] == REG_COUNT);

    assign flush   = wr_ctrl & wr_data[1];
    assign pop_req = wr_data_sel & ~flush;
    assign pop_ok  = pop_req & (occ_reg != 2'd0);
    assign udf_set = pop_req & (occ_reg == 2'd0);

    // A word from a read issued in (or before) a flush cycle never lands in the buffer.
    assign push_req = fifo_data_valid & ~fifo_rd_rst_busy & ~drop_reg & ~flush;
    assign push_ok  = push_req & ((occ_reg != 2'd2) | pop_ok);
    assign ovf_set  = push_req & (occ_reg == 2'd2) & ~pop_ok;

    assign buf_valid = (occ_reg != 2'd0);
    assign buf_full  = (occ_reg == 2'd2);

    assign occ_sum    = {1'b0, occ_reg} + {2'b00, pop_ok};
    assign fifo_rd_en = enable_reg & ~fifo_empty & ~fifo_rd_rst_busy & ~inflight_reg
                        & (occ_sum < 3'd2);

    always_comb begin
        occ_next = occ_reg;
        if (flush) begin
            occ_next = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   occ_next = occ_reg + 2'd1;
                2'b01:   occ_next = occ_reg - 2'd1;
                default: occ_next = occ_reg;
            endcase
        end
    end

    // Buffer storage: data only, no reset needed since occupancy gates visibility.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    word_reg <= fifo_dout;
                end
            end
        end
    endgenerate

    always_comb begin
        head = '0;
        if (buf_valid) begin
            head = rd_ptr_reg ? g_entry[1].word_reg : g_entry[0].word_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg      <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            inflight_reg <= 1'b0;
            drop_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            enable_reg   <= 1'b0;
            count_reg    <= 32'd0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_en;
            drop_reg     <= flush & fifo_rd_en;

            if (flush) begin
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
            end else begin
                if (pop_ok) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                if (push_ok) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
            end

            // Sticky flags: a new event in the clearing cycle wins.
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (wr_stat && wr_data[4]) begin
                ovf_reg <= 1'b0;
            end
            if (udf_set) begin
                udf_reg <= 1'b1;
            end else if (wr_stat && wr_data[5]) begin
                udf_reg <= 1'b0;
            end

            if (wr_ctrl) begin
                enable_reg <= wr_data[0];
            end

            if (wr_count) begin
                count_reg <= 32'd0;
            end else if (pop_ok) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

`ifdef FIFO_RD_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_reg <= wr_data[2];
            end
            irq_reg <= irq_en_reg & buf_valid;
        end
    end

    assign irq         = irq_reg;
    assign ctrl_irq_en = irq_en_reg;
`else
    assign ctrl_irq_en = 1'b0;
`endif

    always_comb begin
        rd_data  = '0;
        head_ext = '0;
        head_ext[DATA_WIDTH-1:0] = head;
        case (addr[1:0])
            REG_DATA:  rd_data = {1'b0, buf_valid, head_ext};
            REG_STAT:  rd_data = {26'd0, udf_reg, ovf_reg, fifo_rd_rst_busy, fifo_empty,
                                  buf_full, buf_valid};
            REG_CTRL:  rd_data = {29'd0, ctrl_irq_en, 1'b0, enable_reg};
            default:   rd_data = count_reg;
        endcase
    end

endmodule
